// File: rtl/circular_shift_pkg.sv
// rtl/circular_shift_pkg.sv - shared types and rotate helper for the circular shifter
package circular_shift_pkg;

    typedef enum logic {
        ROT_LEFT  = 1'b0,
        ROT_RIGHT = 1'b1
    } rot_dir_t;

    // Widest word the helper handles; callers cast their N-bit data in and out.
    localparam int MAX_N = 64;

    // Rotate the low n bits of data by 2**k in the given direction; bits above n read as 0.
    function automatic logic [MAX_N-1:0] rotate_by_pow2(
        input logic [MAX_N-1:0] data,
        input int               n,
        input int               k,
        input rot_dir_t         dir
    );
        logic [MAX_N-1:0] res;
        int               s;
        res = '0;
        s   = (1 << k) % n;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                if (dir == ROT_LEFT) begin
                    res[i] = data[(i - s + n) % n];
                end else begin
                    res[i] = data[(i + s) % n];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/circular_shift_stage.sv
// rtl/circular_shift_stage.sv - one pipeline stage rotating by 2**K when amount bit K is set
module circular_shift_stage
    import circular_shift_pkg::*;
#(
    parameter int  N = 8,
    parameter int  K = 0,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [N-1:0] in_data,
    input  logic [W-1:0] in_amt,
    input  logic         in_dir,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [N-1:0] out_data,
    output logic [W-1:0] out_amt,
    output logic         out_dir
);

    logic         vld_q;
    logic [N-1:0] data_q;
    logic [N-1:0] data_d;
    logic [W-1:0] amt_q;
    logic         dir_q;

    // Stage is free when empty or when its occupant leaves this cycle.
    assign in_rdy   = ~vld_q | out_rdy;
    assign out_vld  = vld_q;
    assign out_data = data_q;
    assign out_amt  = amt_q;
    assign out_dir  = dir_q;

    // Apply this stage's power-of-two rotation only when its amount bit is set.
    always_comb begin
        data_d = in_data;
        if (in_amt[K]) begin
            data_d = N'(rotate_by_pow2(MAX_N'(in_data), N, K, rot_dir_t'(in_dir)));
        end
    end

    // Stage register: valid follows upstream on load; payload only captured with a valid item.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            amt_q  <= '0;
            dir_q  <= 1'b0;
        end else if (in_rdy) begin
            vld_q <= in_vld;
            if (in_vld) begin
                data_q <= data_d;
                amt_q  <= in_amt;
                dir_q  <= in_dir;
            end
        end
    end

endmodule

// File: rtl/pipelined_circular_shifter.sv
// rtl/pipelined_circular_shifter.sv - W-stage valid/ready pipelined variable rotator
module pipelined_circular_shifter
    import circular_shift_pkg::*;
#(
    parameter int  N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_vld,
    output logic         up_rdy,
    input  logic [N-1:0] up_data,
    input  logic [W-1:0] up_amt,
    input  logic         up_dir,
    output logic         down_vld,
    input  logic         down_rdy,
    output logic [N-1:0] down_data
);

    // Index k is the input side of stage k; index W is the pipeline output.
    logic [W:0]   vld_c;
    logic [W:0]   rdy_c;
    logic [W:0]   dir_c;
    logic [N-1:0] data_c [W+1];
    logic [W-1:0] amt_c  [W+1];
    logic         unused_tail;

    assign vld_c[0]  = up_vld;
    assign data_c[0] = up_data;
    assign amt_c[0]  = up_amt;
    assign dir_c[0]  = up_dir;
    assign rdy_c[W]  = down_rdy;

    assign up_rdy    = rdy_c[0];
    assign down_vld  = vld_c[W];
    assign down_data = data_c[W];

    // Amount and direction are fully consumed by the last stage.
    assign unused_tail = ^{amt_c[W], dir_c[W]};

    for (genvar k = 0; k < W; k++) begin : g_stage
        circular_shift_stage #(
            .N (N),
            .K (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .in_vld   (vld_c[k]),
            .in_rdy   (rdy_c[k]),
            .in_data  (data_c[k]),
            .in_amt   (amt_c[k]),
            .in_dir   (dir_c[k]),
            .out_vld  (vld_c[k+1]),
            .out_rdy  (rdy_c[k+1]),
            .out_data (data_c[k+1]),
            .out_amt  (amt_c[k+1]),
            .out_dir  (dir_c[k+1])
        );
    end

endmodule
